// File: rtl/mem_req_arbiter.sv
// Four-port DDR command arbiter. Starvation-aware priority, one command in flight, and a tag FIFO
// that routes in-order read returns back to the port that issued each read.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W    = 27,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned AGE_LIMIT = 32,
  parameter int unsigned MAX_RD    = 8
) (
  input  logic                clk,
  input  logic                ui_rst,
  input  logic [3:0]          req,
  input  logic [3:0]          req_wr,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          grant,
  output logic                out_valid,
  output logic                out_wr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  input  logic                out_ack,
  input  logic [DATA_W-1:0]   rd_data_in,
  input  logic                rd_valid_in,
  output logic [DATA_W-1:0]   rd_data,
  output logic [3:0]          rd_valid,
  output logic                busy,
  output logic                rd_err
);

  localparam int unsigned PtrW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int unsigned CntW = $clog2(MAX_RD + 1);
  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
  localparam logic [CntW-1:0] RdMax  = CntW'(MAX_RD);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(AGE_LIMIT);

  typedef enum logic {StIdle, StIssue} state_e;
  state_e state_q, state_d;

  logic [3:0]        elig, starve;
  logic [1:0]        sel, win_q;
  logic              any_elig, launch, accept, push, pop, cool_q;
  logic [AgeW-1:0]   age_q [4];
  logic              out_wr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_wdata_q;
  logic [1:0]        tag_mem [MAX_RD];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   rd_cnt_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [3:0]        rd_valid_q;
  logic              rd_err_q;

  // Lowest-index starving port wins; otherwise lowest-index eligible port.
  always_comb begin
    elig   = '0;
    starve = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i]   = req[i] & (req_wr[i] | (rd_cnt_q < RdMax));
      starve[i] = elig[i] & (age_q[i] >= AgeMax);
    end
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) sel = 2'(i);
    end
    if (|starve) begin
      for (int i = 3; i >= 0; i--) begin
        if (starve[i]) sel = 2'(i);
      end
    end
    any_elig = |elig;
  end

  // cool_q holds off arbitration the cycle after a grant, while the granted req may still be stale.
  assign launch = (state_q == StIdle) && any_elig && !cool_q;
  assign accept = (state_q == StIssue) && out_ack;
  assign push   = accept && !out_wr_q;
  assign pop    = rd_valid_in && (rd_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (ui_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch)  state_d = StIssue;
      StIssue: if (out_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant     = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state_q == StIssue) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      if (out_ack && !ui_rst) grant = 4'b0001 << win_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ui_rst) begin
      cool_q      <= 1'b0;
      win_q       <= '0;
      out_wr_q    <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      cool_q <= accept;
      if (launch) begin
        win_q       <= sel;
        out_wr_q    <= req_wr[sel];
        out_addr_q  <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
        out_wdata_q <= req_wdata[int'(sel)*DATA_W +: DATA_W];
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || grant[i])     age_q[i] <= '0;
        else if (age_q[i] < AgeMax)  age_q[i] <= age_q[i] + 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      rd_cnt_q <= rd_cnt_q + 1'b1;
      else if (pop && !push) rd_cnt_q <= rd_cnt_q - 1'b1;
      rd_valid_q <= pop ? (4'b0001 << tag_mem[rd_ptr_q]) : 4'b0000;
      if (pop) rd_data_q <= rd_data_in;
      if (rd_valid_in && (rd_cnt_q == '0)) rd_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !ui_rst) tag_mem[wr_ptr_q] <= win_q;
  end

  assign out_wr    = out_wr_q;
  assign out_addr  = out_addr_q;
  assign out_wdata = out_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: table of single-arbitration vectors, then hand-written
// sequences for fairness, read-credit limit, return routing, error flag and reset abandonment.
module tb_mem_req_arbiter;
  localparam int unsigned AW = 27, DW = 128, AGE = 32, MRD = 8;

  logic            clk = 1'b0;
  logic            ui_rst;
  logic [3:0]      req, req_wr, grant, rd_valid;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic            out_valid, out_wr, out_ack, rd_valid_in, busy, rd_err;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_wdata, rd_data_in, rd_data;

  int n_vec = 0, n_err = 0;
  int g0, g3, cnt, found, got, lat, bad, gcnt;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_LIMIT(AGE), .MAX_RD(MRD)) dut (
    .clk(clk), .ui_rst(ui_rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .out_valid(out_valid), .out_wr(out_wr),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_ack(out_ack), .rd_data_in(rd_data_in),
    .rd_valid_in(rd_valid_in), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wr;
    int         port;
    logic       exp_wr;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [AW-1:0] addr_of(input int p);
    return AW'(32'h0012_3400 + 32'(p));
  endfunction

  function automatic logic [DW-1:0] data_of(input int p);
    logic [31:0] w;
    w = 32'hCAFE_0000 + 32'(p);
    return {4{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ui_rst = 1'b1; req = '0; req_wr = '0; out_ack = 1'b0; rd_valid_in = 1'b0;
    tick();
    tick();
    ui_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW]  = addr_of(i);
      req_wdata[i*DW +: DW] = data_of(i);
    end
    rd_data_in = '0;
    vecs[0] = '{req: 4'b0001, wr: 4'b0001, port: 0, exp_wr: 1'b1};
    vecs[1] = '{req: 4'b1000, wr: 4'b0000, port: 3, exp_wr: 1'b0};
    vecs[2] = '{req: 4'b0110, wr: 4'b0010, port: 1, exp_wr: 1'b1};
    vecs[3] = '{req: 4'b1100, wr: 4'b0100, port: 2, exp_wr: 1'b1};
    vecs[4] = '{req: 4'b1111, wr: 4'b0000, port: 0, exp_wr: 1'b0};
    vecs[5] = '{req: 4'b1010, wr: 4'b1000, port: 1, exp_wr: 1'b0};
    vecs[6] = '{req: 4'b0100, wr: 4'b0000, port: 2, exp_wr: 1'b0};

    // Reset state with busy-looking inputs applied.
    ui_rst = 1'b1; req = 4'hF; req_wr = 4'hF; out_ack = 1'b1; rd_valid_in = 1'b1;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_wdata", out_wdata, 0);
    check("rst_out_wr", out_wr, 0);
    check("rst_rd_data", rd_data, 0);

    // Table: one arbitration from a fresh reset per vector.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      req = vecs[v].req; req_wr = vecs[v].wr; out_ack = 1'b0;
      #1;
      check("vec_idle_valid", out_valid, 0);
      tick();
      #1;
      check("vec_out_valid", out_valid, 1);
      check("vec_busy", busy, 1);
      check("vec_out_addr", out_addr, addr_of(vecs[v].port));
      check("vec_out_wdata", out_wdata, data_of(vecs[v].port));
      check("vec_out_wr", out_wr, vecs[v].exp_wr);
      check("vec_no_grant_before_ack", grant, 0);
      out_ack = 1'b1;
      #1;
      check("vec_grant", grant, 4'(1) << vecs[v].port);
      tick();
      req = '0; out_ack = 1'b0;
      #1;
      check("vec_valid_dropped", out_valid, 0);
      check("vec_grant_pulse", grant, 0);
    end

    // Two writers, immediate ack: port 0 first, port 3 three cycles later.
    do_reset();
    req_wr = 4'b1001; out_ack = 1'b1; req = 4'b1001; g0 = -1; g3 = -1;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] clr;
      clr = '0;
      #1;
      if (grant[0] && g0 < 0) g0 = c;
      if (grant[3] && g3 < 0) g3 = c;
      clr = grant;
      tick();
      req = req & ~clr;
    end
    check("two_wr_port0_cycle", g0, 1);
    check("two_wr_port3_spacing", g3 - g0, 3);

    // Port 0 re-requests forever; port 3 must win once it has aged out.
    do_reset();
    req_wr = 4'b1001; out_ack = 1'b1; req = 4'b0001; g3 = -1;
    for (int c = 0; c < 80; c++) begin
      if (c == 6) req[3] = 1'b1;
      #1;
      if (grant[3] && g3 < 0) g3 = c;
      tick();
    end
    req = '0;
    lat = g3 - 6;
    check("starve_grant_seen", g3 >= 0, 1);
    check("starve_latency_le_35", lat <= 35, 1);
    check("starve_latency_ge_33", lat >= 33, 1);

    // Read credit: eight reads issue, the ninth waits for one return.
    do_reset();
    req_wr = 4'b0000; req = 4'b1000; out_ack = 1'b1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (grant[3]) cnt++;
      tick();
    end
    check("reads_before_full", cnt, 8);
    check("full_busy", busy, 0);
    check("full_out_valid", out_valid, 0);
    rd_data_in = 128'h55; rd_valid_in = 1'b1;
    tick();
    rd_valid_in = 1'b0;
    #1;
    check("full_ret_rd_valid", rd_valid, 4'b1000);
    check("full_ret_rd_data", rd_data, 128'h55);
    found = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      if (grant[3]) found++;
    end
    check("ninth_read_issued_once", found, 1);
    req = '0;

    // Return routing for reads from ports 2, 3, 2.
    do_reset();
    out_ack = 1'b1; req_wr = '0;
    for (int k = 0; k < 3; k++) begin
      int p;
      p = (k == 1) ? 3 : 2;
      req = 4'(1) << p; got = 0;
      for (int c = 0; c < 8 && got == 0; c++) begin
        #1;
        got = int'(grant[p]);
        tick();
      end
      req = '0;
      check("route_read_issued", got, 1);
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0]    exp_v;
      logic [DW-1:0] val;
      exp_v = (k == 1) ? 4'b1000 : 4'b0100;
      val = DW'(32'hA + 32'(k));
      rd_data_in = val; rd_valid_in = 1'b1;
      tick();
      rd_valid_in = 1'b0;
      #1;
      check("route_rd_valid", rd_valid, exp_v);
      check("route_rd_data", rd_data, val);
      tick();
      check("route_one_cycle", rd_valid, 0);
    end

    // Return with nothing outstanding sets the sticky error.
    do_reset();
    rd_valid_in = 1'b1;
    tick();
    rd_valid_in = 1'b0;
    #1;
    check("err_set", rd_err, 1);
    check("err_no_rd_valid", rd_valid, 0);
    repeat (5) tick();
    check("err_sticky", rd_err, 1);
    ui_rst = 1'b1;
    tick();
    ui_rst = 1'b0;
    check("err_cleared_by_reset", rd_err, 0);

    // Stalled command stays stable; reset abandons it without a grant.
    do_reset();
    out_ack = 1'b0; req_wr = 4'b0010; req = 4'b0010;
    tick();
    #1;
    check("stall_out_valid", out_valid, 1);
    bad = 0; gcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_addr !== addr_of(1) || out_wdata !== data_of(1) || out_valid !== 1'b1) bad++;
      if (grant !== 4'b0000) gcnt++;
      tick();
    end
    check("stall_stable", bad, 0);
    check("stall_no_grant", gcnt, 0);
    ui_rst = 1'b1; out_ack = 1'b1;
    #1;
    check("rst_in_issue_no_grant", grant, 0);
    tick();
    ui_rst = 1'b0; out_ack = 1'b0; req = '0;
    #1;
    check("rst_in_issue_valid", out_valid, 0);
    check("rst_in_issue_busy", busy, 0);
    tick();
    check("rst_in_issue_after_grant", grant, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
